// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared widths, defaults, FSM encoding and clamped step helper
package freq_pkg;
  localparam int FREQ_W = 20;
  localparam int ACC_W  = 24;

  localparam logic [FREQ_W-1:0] F_INIT_DEF = 20'd13422;
  localparam logic [FREQ_W-1:0] F_MIN_DEF  = 20'd10066;
  localparam logic [FREQ_W-1:0] F_MAX_DEF  = 20'd16777;
  localparam logic [FREQ_W-1:0] STEP_DEF   = 20'd34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // One extra bit of headroom so the limit compare can never see a wrapped sum.
  function automatic logic [FREQ_W-1:0] step_freq(
    input logic [FREQ_W-1:0] f,
    input logic              up,
    input logic [FREQ_W-1:0] f_min,
    input logic [FREQ_W-1:0] f_max,
    input logic [FREQ_W-1:0] step
  );
    logic [FREQ_W:0]   sum;
    logic [FREQ_W:0]   floor_lim;
    logic [FREQ_W-1:0] res;
    sum       = {1'b0, f} + {1'b0, step};
    floor_lim = {1'b0, f_min} + {1'b0, step};
    if (up) begin
      res = (sum > {1'b0, f_max}) ? f_max : sum[FREQ_W-1:0];
    end else begin
      res = ({1'b0, f} < floor_lim) ? f_min : f - step;
    end
    return res;
  endfunction
endpackage

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - 24-bit phase accumulator with registered square-wave output
module phase_acc
  import freq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] tuning_word,
  output logic              drive_out
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             drive_q, drive_d;

  always_comb begin
    acc_d   = acc_q + {{(ACC_W-FREQ_W){1'b0}}, tuning_word};
    drive_d = acc_q[ACC_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      drive_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      drive_q <= drive_d;
    end
  end

  assign drive_out = drive_q;
endmodule

// File: rtl/freq_stepper.sv
// rtl/freq_stepper.sv - clamped tuning-word stepper FSM driving a phase-accumulator oscillator
module freq_stepper
  import freq_pkg::*;
#(
  parameter logic [FREQ_W-1:0] F_INIT        = F_INIT_DEF,
  parameter logic [FREQ_W-1:0] F_MIN         = F_MIN_DEF,
  parameter logic [FREQ_W-1:0] F_MAX         = F_MAX_DEF,
  parameter logic [FREQ_W-1:0] STEP          = STEP_DEF,
  parameter logic [FREQ_W-1:0] SETTLE_CYCLES = 20'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              freq_ready,
  input  logic              freq_set_up_down,
  input  logic              freq_opt,
  output logic [FREQ_W-1:0] freq,
  output logic              data_start,
  output logic              drive_out,
  output logic              at_limit,
  output logic              locked
);
  // Assertion passes straight through; release is delayed two clk edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= rst_sync_d;
  end

  assign rst_int = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_CYCLES - 20'd1;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_START;
          else             cnt_d   = cnt_q - 20'd1;
        end
        ST_START: state_d = ST_WAIT;
        ST_WAIT, ST_HOLD: begin
          if (freq_ready && freq_opt) begin
            state_d = ST_HOLD;
          end else if (freq_ready) begin
            freq_d  = step_freq(freq_q, freq_set_up_down, F_MIN, F_MAX, STEP);
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_CYCLES - 20'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= ST_IDLE;
      freq_q  <= F_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
    end
  end

  phase_acc u_phase_acc (
    .clk         (clk),
    .rst         (rst_int),
    .tuning_word (freq_q),
    .drive_out   (drive_out)
  );

  assign freq       = freq_q;
  assign data_start = (state_q == ST_START);
  assign at_limit   = (freq_q == F_MAX) || (freq_q == F_MIN);
  assign locked     = (state_q == ST_HOLD);
endmodule

// File: tb/tb_freq_stepper.sv
// tb/tb_freq_stepper.sv - scoreboard bench for freq_stepper
module tb_freq_stepper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, freq_ready = 1'b0, ud = 1'b0, opt = 1'b0;
  logic [19:0] freq;
  logic        data_start, drive_out, at_limit, locked;

  logic        en2 = 1'b0, ready2 = 1'b0;
  logic [19:0] freq2;
  logic        data_start2, drive_out2, at_limit2, locked2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ds2_cnt = 0;

  typedef struct {
    int          cyc;
    logic [19:0] f;
  } exp_t;
  exp_t exp_q[$];

  freq_stepper #(.SETTLE_CYCLES(20'd100)) dut (
    .clk(clk), .rst(rst), .en(en), .freq_ready(freq_ready),
    .freq_set_up_down(ud), .freq_opt(opt), .freq(freq),
    .data_start(data_start), .drive_out(drive_out),
    .at_limit(at_limit), .locked(locked)
  );

  freq_stepper #(.F_INIT(20'd16770), .SETTLE_CYCLES(20'd100)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .freq_ready(ready2),
    .freq_set_up_down(1'b1), .freq_opt(1'b0), .freq(freq2),
    .data_start(data_start2), .drive_out(drive_out2),
    .at_limit(at_limit2), .locked(locked2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [19:0] f);
    exp_t e;
    e.cyc = c;
    e.f   = f;
    exp_q.push_back(e);
  endtask

  task automatic pulse_ready(input logic o, input logic u);
    freq_ready = 1'b1;
    opt = o;
    ud = u;
    tick(1);
    freq_ready = 1'b0;
    opt = 1'b0;
  endtask

  always @(negedge clk) begin
    if (data_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_data_start: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ds_cycle", cyc, e.cyc);
        check("ds_freq", {12'd0, freq}, {12'd0, e.f});
      end
    end
    if (data_start2 === 1'b1) ds2_cnt++;
  end

  initial begin
    int n, hi, lo;
    tick(3);
    check("rst_freq", freq, 20'd13422);
    check("rst_drive", drive_out, 0);
    check("rst_ds", data_start, 0);
    check("rst_at_limit", at_limit, 0);
    check("rst_locked", locked, 0);
    check("rst_freq2", freq2, 20'd16770);
    check("rst_at_limit2", at_limit2, 0);
    rst = 1'b0;
    tick(4);

    en = 1'b1;
    push(cyc + 101, 20'd13422);
    tick(102);

    push(cyc + 101, 20'd13456);
    pulse_ready(1'b0, 1'b1);
    check("step_up_freq", freq, 20'd13456);
    check("step_up_at_limit", at_limit, 0);
    tick(101);

    pulse_ready(1'b1, 1'b0);
    check("lock_locked", locked, 1);
    check("lock_freq", freq, 20'd13456);
    for (int i = 0; i < 10; i++) begin
      pulse_ready(1'b1, 1'b1);
      check("hold_freq", freq, 20'd13456);
      check("hold_locked", locked, 1);
      tick(1);
    end
    push(cyc + 101, 20'd13422);
    pulse_ready(1'b0, 1'b0);
    check("unlock_freq", freq, 20'd13422);
    check("unlock_locked", locked, 0);
    tick(101);

    n = 0;
    while (drive_out !== 1'b0 && n < 1300) begin tick(1); n++; end
    while (drive_out !== 1'b1 && n < 2600) begin tick(1); n++; end
    hi = 0;
    while (drive_out === 1'b1 && hi < 2000) begin tick(1); hi++; end
    lo = 0;
    while (drive_out === 1'b0 && lo < 2000) begin tick(1); lo++; end
    check_range("drive_period", hi + lo, 1249, 1251);
    check_range("drive_high", hi, 624, 626);

    en = 1'b0;
    freq_ready = 1'b1;
    ud = 1'b1;
    tick(1);
    freq_ready = 1'b0;
    check("en_priority_freq", freq, 20'd13422);
    tick(5);
    en = 1'b1;
    push(cyc + 101, 20'd13422);
    tick(102);

    en2 = 1'b1;
    tick(102);
    check("clamp_ds_count0", ds2_cnt, 1);
    ready2 = 1'b1;
    tick(1);
    ready2 = 1'b0;
    check("clamp_freq", freq2, 20'd16777);
    check("clamp_at_limit", at_limit2, 1);
    tick(101);
    check("clamp_ds_count1", ds2_cnt, 2);
    ready2 = 1'b1;
    tick(1);
    ready2 = 1'b0;
    check("clamp_hold_freq", freq2, 20'd16777);
    tick(101);
    check("clamp_ds_count2", ds2_cnt, 3);
    check("clamp_hold_at_limit", at_limit2, 1);
    en2 = 1'b0;

    pulse_ready(1'b0, 1'b1);
    check("pre_rst_freq", freq, 20'd13456);
    tick(50);
    rst = 1'b1;
    #1;
    check("midrst_freq", freq, 20'd13422);
    check("midrst_drive", drive_out, 0);
    check("midrst_ds", data_start, 0);
    tick(3);
    rst = 1'b0;
    push(cyc + 103, 20'd13422);
    tick(110);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
